// File: rtl/mp64_pkg.sv
// Shared constants, FSM encodings and PHY command payload for the MP64 PHY master.
package mp64_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned BURST_W    = 4;
  localparam int unsigned BEATS_W    = BURST_W + 1;
  localparam int unsigned BEAT_BYTES = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               wen;
    logic [DATA_W-1:0]  wdata;
    logic [BURST_W-1:0] burst_len;
  } phy_cmd_t;

  // Round a byte address down to its 8-byte beat boundary.
  function automatic logic [ADDR_W-1:0] beat_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/mp64_phy_wdog.sv
// WAIT-state watchdog for the MP64 PHY master; only built with MP64_PHY_TIMEOUT_EN.
module mp64_phy_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive WAIT cycles; any other state clears it.
  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_c_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mp64_phy_master.sv
// Single-command PHY initiator: read bursts and single-beat writes.
// Optional completion timeout enabled by defining MP64_PHY_TIMEOUT_EN.
module mp64_phy_master
  import mp64_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wen,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_last,
  output logic               wr_done,
  output logic               err,
  output logic               phy_req,
  output logic [ADDR_W-1:0]  phy_addr,
  output logic               phy_wen,
  output logic [DATA_W-1:0]  phy_wdata,
  output logic [BURST_W-1:0] phy_burst_len,
  input  logic [DATA_W-1:0]  phy_rdata,
  input  logic               phy_rvalid,
  input  logic               phy_ready
);

  logic [1:0]         state_q, state_d;
  phy_cmd_t           cmd_q, cmd_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic               phy_req_q, phy_req_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               wr_done_q, wr_done_d;
  logic               err_q, err_d;
  logic               beat_c, done_c, expired_c;

`ifdef MP64_PHY_TIMEOUT_EN
  mp64_phy_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .run_i       (state_q == ST_WAIT),
    .expired_c_o (expired_c)
  );
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign expired_c          = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE) && phy_ready && !rst;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    beats_d     = beats_q;
    phy_req_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data_q;
    wr_done_d   = 1'b0;
    err_d       = 1'b0;
    beat_c      = 1'b0;
    done_c      = 1'b0;

    // Beats are forwarded only while a read burst still has beats outstanding.
    if ((state_q == ST_SETTLE || state_q == ST_WAIT) && !cmd_q.wen &&
        beats_q != '0 && phy_rvalid) begin
      beat_c      = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_data_d  = phy_rdata;
      rsp_last_d  = (beats_q == BEATS_W'(1));
      beats_d     = beats_q - BEATS_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.addr      = beat_align(cmd_addr);
          cmd_d.wen       = cmd_wen;
          cmd_d.wdata     = cmd_wdata;
          cmd_d.burst_len = cmd_wen ? '0 : cmd_len;
          beats_d         = cmd_wen ? '0 : BEATS_W'(cmd_len) + BEATS_W'(1);
          phy_req_d       = 1'b1;
          state_d         = ST_REQ;
        end
      end
      ST_REQ:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cmd_q.wen) begin
          done_c    = phy_ready;
          wr_done_d = phy_ready;
        end else begin
          done_c = (beats_q == '0) || (beat_c && beats_q == BEATS_W'(1));
        end
        if (done_c) begin
          state_d = ST_IDLE;
        end else if (expired_c) begin
          err_d   = 1'b1;
          beats_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      beats_q     <= '0;
      phy_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      beats_q     <= beats_d;
      phy_req_q   <= phy_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      wr_done_q   <= wr_done_d;
      err_q       <= err_d;
    end
  end

  assign phy_req       = phy_req_q;
  assign phy_addr      = cmd_q.addr;
  assign phy_wen       = cmd_q.wen;
  assign phy_wdata     = cmd_q.wdata;
  assign phy_burst_len = cmd_q.burst_len;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_last      = rsp_last_q;
  assign rsp_data      = rsp_data_q;
  assign wr_done       = wr_done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mp64_phy_master.sv
// Bench for mp64_phy_master: 1-cycle-latency PHY over a 256 KiB store plus a shadow memory model.
module tb_mp64_phy_master;

  localparam int unsigned TO_CYC    = 16;
  localparam int unsigned MEM_WORDS = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wen = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_last, wr_done, err;
  logic [63:0] rsp_data;
  logic        phy_req, phy_wen;
  logic [31:0] phy_addr;
  logic [63:0] phy_wdata;
  logic [3:0]  phy_burst_len;
  logic [63:0] phy_rdata = '0;
  logic        phy_rvalid = 1'b0;
  logic        phy_ready = 1'b0;

  mp64_phy_master #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .err(err),
    .phy_req(phy_req), .phy_addr(phy_addr), .phy_wen(phy_wen),
    .phy_wdata(phy_wdata), .phy_burst_len(phy_burst_len),
    .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid), .phy_ready(phy_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem   [MEM_WORDS];
  logic [63:0] model [MEM_WORDS];

  // PHY model: copies the initial image on its first edge, then serves one request at a time.
  logic        loaded  = 1'b0;
  logic        stuck   = 1'b0;
  logic        wr_pend = 1'b0;
  logic [14:0] w_idx   = '0;
  logic [63:0] w_data  = '0;
  logic [14:0] rd_idx  = '0;
  logic [4:0]  rd_left = '0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = model[i];
      loaded = 1'b1;
    end
    phy_rvalid <= 1'b0;
    if (phy_req) begin
      phy_ready <= 1'b0;
      if (!stuck) begin
        if (phy_wen) begin
          wr_pend <= 1'b1;
          w_idx   <= phy_addr[17:3];
          w_data  <= phy_wdata;
        end else begin
          rd_left <= 5'(phy_burst_len) + 5'd1;
          rd_idx  <= phy_addr[17:3];
        end
      end
    end else if (wr_pend) begin
      mem[w_idx] = w_data;
      wr_pend   <= 1'b0;
      phy_ready <= 1'b1;
    end else if (rd_left != 5'd0) begin
      phy_rvalid <= 1'b1;
      phy_rdata  <= mem[rd_idx];
      rd_idx     <= rd_idx + 15'd1;
      rd_left    <= rd_left - 5'd1;
    end else if (!stuck) begin
      phy_ready <= 1'b1;
    end
  end

  // Passive monitor, sampled on the falling edge.
  int          cyc = 0, req_cyc = 0, wr_cnt = 0, err_cnt = 0, last_cnt = 0;
  int          stab_viol = 0, min_gap = 1000, last_req_t = -1000, req_t = 0, err_t = 0;
  logic        act = 1'b0;
  logic [31:0] cap_addr = '0;
  logic        cap_wen = 1'b0;
  logic [3:0]  cap_len = '0;
  logic [63:0] cap_wdata = '0;
  logic [63:0] rq_data[$];
  logic        rq_last[$];

  always @(negedge clk) begin
    cyc++;
    if (rsp_valid) begin
      rq_data.push_back(rsp_data);
      rq_last.push_back(rsp_last);
    end
    if (rst) begin
      act = 1'b0;
    end else begin
      if (phy_req) begin
        req_cyc++;
        if (cyc - last_req_t < min_gap) min_gap = cyc - last_req_t;
        last_req_t = cyc;
        req_t      = cyc;
        cap_addr   = phy_addr;
        cap_wen    = phy_wen;
        cap_len    = phy_burst_len;
        cap_wdata  = phy_wdata;
        act        = 1'b1;
      end else if (act && {phy_addr, phy_wen, phy_burst_len, phy_wdata} !=
                          {cap_addr, cap_wen, cap_len, cap_wdata}) begin
        stab_viol++;
      end
      if (wr_done) wr_cnt++;
      if (err) begin
        err_cnt++;
        err_t = cyc;
      end
      if (rsp_valid && rsp_last) last_cnt++;
      if (wr_done || err || (rsp_valid && rsp_last)) act = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int dsum();
    return wr_cnt + last_cnt + err_cnt;
  endfunction

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [3:0] len,
                       input logic [63:0] wd);
    int n = 0;
    cmd_wen = wen; cmd_addr = addr; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    chk("accept_bound", 64'(n < 200), 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (dsum() == base && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_done_bound"}, 64'(n < 100), 64'd1);
    step();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input string tag);
    int b  = dsum();
    int r0 = req_cyc;
    int idx = int'(addr[17:3]);
    rq_data.delete();
    rq_last.delete();
    issue(1'b0, addr, len, 64'd0);
    wait_done(b, tag);
    chk({tag, "_req_cycles"}, 64'(req_cyc - r0), 64'd1);
    chk({tag, "_phy_addr"}, 64'(cap_addr), 64'(addr & 32'hFFFF_FFF8));
    chk({tag, "_burst_len"}, 64'(cap_len), 64'(len));
    chk({tag, "_nbeats"}, 64'(rq_data.size()), 64'(int'(len) + 1));
    for (int k = 0; k < rq_data.size(); k++) begin
      chk({tag, "_data"}, rq_data[k], model[idx + k]);
      chk({tag, "_last"}, 64'(rq_last[k]), 64'(k == int'(len)));
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [63:0] wd,
                          input string tag);
    int b  = dsum();
    int r0 = req_cyc;
    int w0 = wr_cnt;
    int idx = int'(addr[17:3]);
    rq_data.delete();
    issue(1'b1, addr, len, wd);
    wait_done(b, tag);
    model[idx] = wd;
    chk({tag, "_req_cycles"}, 64'(req_cyc - r0), 64'd1);
    chk({tag, "_phy_addr"}, 64'(cap_addr), 64'(addr & 32'hFFFF_FFF8));
    chk({tag, "_burst_len"}, 64'(cap_len), 64'd0);
    chk({tag, "_phy_wen"}, 64'(cap_wen), 64'd1);
    chk({tag, "_wr_done"}, 64'(wr_cnt - w0), 64'd1);
    chk({tag, "_mem"}, mem[idx], wd);
    chk({tag, "_no_rsp"}, 64'(rq_data.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_phy_req"}, 64'(phy_req), 64'd0);
    chk({tag, "_phy_wen"}, 64'(phy_wen), 64'd0);
    chk({tag, "_phy_addr"}, 64'(phy_addr), 64'd0);
    chk({tag, "_phy_wdata"}, phy_wdata, 64'd0);
    chk({tag, "_phy_burst_len"}, 64'(phy_burst_len), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_last"}, 64'(rsp_last), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_wr_done"}, 64'(wr_done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n, acc, l0, r0, b, e0;
    logic [31:0] ba [3];
    for (int i = 0; i < MEM_WORDS; i++) model[i] = {$urandom, $urandom};
    model[32'h21] = 64'hDEAD_BEEF_CAFE_F00D;

    rst = 1'b1;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    do_read(32'h0000_0108, 4'd0, "single_rd");
    chk("single_rd_value", (rq_data.size() > 0) ? rq_data[0] : 64'd0, 64'hDEAD_BEEF_CAFE_F00D);
    do_read(32'h0000_0200, 4'd3, "burst_rd");
    do_write(32'h0000_0013, 4'd5, 64'h0123_4567_89AB_CDEF, "wr");
    do_read(32'h0000_0010, 4'd0, "wr_readback");
    do_read(32'h0000_0400, 4'd15, "max_burst");

    // Three reads with cmd_valid held high throughout.
    ba[0] = 32'h0000_1000; ba[1] = 32'h0000_2008; ba[2] = 32'h0000_3010;
    rq_data.delete(); rq_last.delete();
    l0 = last_cnt; r0 = req_cyc; min_gap = 1000;
    cmd_wen = 1'b0; cmd_len = 4'd1; cmd_addr = ba[0]; cmd_valid = 1'b1;
    acc = 0; n = 0;
    while (acc < 3 && n < 200) begin
      if (cmd_ready) begin
        acc++;
        step();
        if (acc < 3) cmd_addr = ba[acc];
      end else begin
        step();
      end
      n++;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (last_cnt - l0 < 3 && n < 200) begin
      step();
      n++;
    end
    step();
    chk("b2b_accepts", 64'(acc), 64'd3);
    chk("b2b_last_pulses", 64'(last_cnt - l0), 64'd3);
    chk("b2b_req_pulses", 64'(req_cyc - r0), 64'd3);
    chk("b2b_min_req_gap", 64'(min_gap >= 4), 64'd1);
    chk("b2b_nbeats", 64'(rq_data.size()), 64'd6);
    for (int k = 0; k < rq_data.size() && k < 6; k++)
      chk("b2b_data", rq_data[k], model[int'(ba[k / 2][17:3]) + (k % 2)]);

    // Reset one cycle after phy_req of a 4-beat read.
    b = dsum();
    issue(1'b0, 32'h0000_0800, 4'd3, 64'd0);
    step();
    rst = 1'b1;
    rq_data.delete();
    step();
    chk_reset_vals("midrst");
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("midrst_no_rsp", 64'(rq_data.size()), 64'd0);
    chk("midrst_no_done", 64'(dsum() - b), 64'd0);
    do_read(32'h0000_0808, 4'd2, "post_rst_rd");

    for (int t = 0; t < 24; t++) begin
      int idx = int'($urandom_range(0, MEM_WORDS - 17));
      logic [31:0] a = {14'd0, 15'(idx), 3'($urandom_range(0, 7))};
      logic [3:0] ln = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, ln, {$urandom, $urandom}, "rnd_wr");
      else do_read(a, ln, "rnd_rd");
    end

    chk("no_err_so_far", 64'(err_cnt), 64'd0);
    chk("phy_stable", 64'(stab_viol), 64'd0);

    // PHY never answers.
    stuck = 1'b1;
    e0 = err_cnt;
    rq_data.delete();
    issue(1'b0, 32'h0000_0900, 4'd2, 64'd0);
`ifdef MP64_PHY_TIMEOUT_EN
    n = 0;
    while (err_cnt == e0 && n < 60) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("to_err_pulses", 64'(err_cnt - e0), 64'd1);
    chk("to_err_delay", 64'(err_t - req_t), 64'(TO_CYC + 2));
    chk("to_no_rsp", 64'(rq_data.size()), 64'd0);
    stuck = 1'b0;
    step();
`else
    repeat (40) step();
    chk("noto_err_cnt", 64'(err_cnt - e0), 64'd0);
    chk("noto_err", 64'(err), 64'd0);
    chk("noto_still_busy", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    stuck = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
`endif
    do_read(32'h0000_0A00, 4'd1, "recover_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
